// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB first.
// Ports: clk/rst, start/op/a/b in, busy/done/result/flags out, slice_* bus.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [2:0]       slice_signal,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_invert,
  output logic             slice_cin,
  output logic             slice_less,
  input  logic             slice_out,
  input  logic             slice_cout,
  input  logic             slice_set
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_AND,
    K_OR,
    K_ADD,
    K_SUB,
    K_SLT
  } kind_t;

  state_t          state;
  kind_t           kind;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic            cout_q;

  logic            last;
  logic            inv;
  logic            arith;
  logic            addsub;

  function automatic kind_t decode(
    input logic [2:0] o
  );
    kind_t k;
    case (o)
      3'b000:  k = K_AND;
      3'b001:  k = K_OR;
      3'b110:  k = K_SUB;
      3'b111:  k = K_SLT;
      default: k = K_ADD;
    endcase
    return k;
  endfunction

  assign last   = (idx == IW'(WIDTH-1));
  assign inv    = (kind == K_SUB) ||
                  (kind == K_SLT);
  assign addsub = (kind == K_ADD) ||
                  (kind == K_SUB);
  assign arith  = addsub ||
                  (kind == K_SLT);

  // Slice drive is combinational from
  // registered state only, so the
  // slice's same-cycle returns never
  // loop back into these outputs.
  always_comb begin
    slice_signal = 3'b000;
    slice_a      = 1'b0;
    slice_b      = 1'b0;
    slice_invert = 1'b0;
    slice_cin    = 1'b0;
    slice_less   = 1'b0;
    if (state == S_RUN) begin
      slice_a      = a_reg[idx];
      slice_b      = b_reg[idx];
      slice_invert = inv;
      // bit 0 takes the +1 of the
      // two's-complement negate
      slice_cin    = (idx == '0) ?
                     inv : cout_q;
      unique case (1'b1)
        kind == K_AND: slice_signal = 3'b000;
        kind == K_OR:  slice_signal = 3'b001;
        kind == K_SLT: slice_signal = 3'b111;
        default:       slice_signal = 3'b010;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      kind      <= K_AND;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cout_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            kind   <= decode(op);
            idx    <= '0;
            cout_q <= 1'b0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          result[idx] <= slice_out;
          cout_q      <= slice_cout;
          if (last) begin
            // SLT answer lives only in
            // the MSB slice's set line
            if (kind == K_SLT)
              result <= {{(WIDTH-1){1'b0}},
                         slice_set};
            carry_out <= arith &
                         slice_cout;
            overflow  <= addsub &
                         (slice_cin ^
                          slice_cout);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq with a behavioural 1-bit slice.
// Directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          overflow;
  logic [2:0]    slice_signal;
  logic          slice_a;
  logic          slice_b;
  logic          slice_invert;
  logic          slice_cin;
  logic          slice_less;
  logic          slice_out;
  logic          slice_cout;
  logic          slice_set;

  int n_tests;
  int n_fail;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .slice_signal (slice_signal),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_invert (slice_invert),
    .slice_cin    (slice_cin),
    .slice_less   (slice_less),
    .slice_out    (slice_out),
    .slice_cout   (slice_cout),
    .slice_set    (slice_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice
  logic bb;
  logic sum;
  assign bb         = slice_b ^ slice_invert;
  assign sum        = slice_a ^ bb ^ slice_cin;
  assign slice_cout = (slice_a & bb) |
                      (slice_a & slice_cin) |
                      (bb & slice_cin);
  assign slice_set  = sum ^ slice_cin ^ slice_cout;
  always_comb begin
    slice_out = 1'b0;
    case (slice_signal)
      3'b000:  slice_out = slice_a & bb;
      3'b001:  slice_out = slice_a | bb;
      3'b010:  slice_out = sum;
      3'b111:  slice_out = slice_less;
      default: slice_out = 1'b0;
    endcase
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r,
    output logic         c,
    output logic         v
  );
    logic [W:0] s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] != y[W-1]) &&
            (r[W-1] != x[W-1]);
      end
      3'b111: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        c = s[W];
        r = ($signed(x) < $signed(y)) ?
            W'(1) : W'(0);
      end
      default: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) &&
            (r[W-1] != x[W-1]);
      end
    endcase
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_slice"},
        64'({slice_signal, slice_a, slice_b,
             slice_invert, slice_cin,
             slice_less}), 64'd0);
  endtask

  // stop_bit: bit at which a stray start
  // is pulsed; rst_bit: bit at which reset
  // aborts the run (-1 = none).
  task automatic run_op(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input int           stop_bit,
    input int           rst_bit
  );
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    logic         inv;
    logic [2:0]   esig;
    model(o, x, y, er, ec, ev);
    inv  = (o == 3'b110) || (o == 3'b111);
    case (o)
      3'b000:  esig = 3'b000;
      3'b001:  esig = 3'b001;
      3'b111:  esig = 3'b111;
      default: esig = 3'b010;
    endcase
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    for (int cnt = 1; cnt <= W + 1; cnt++) begin
      @(negedge clk);
      if (cnt <= W) begin
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_done", 64'(done), 64'd0);
        chk("slice_ab",
            64'({slice_a, slice_b}),
            64'({x[cnt-1], y[cnt-1]}));
        chk("slice_ctl",
            64'({slice_invert, slice_signal,
                 slice_less}),
            64'({inv, esig, 1'b0}));
        if (cnt == 1)
          chk("cin0", 64'(slice_cin), 64'(inv));
        if (cnt - 1 == rst_bit) begin
          rst   = 1'b1;
          start = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_done", 64'(done), 64'd0);
          chk("abort_res",
              64'({result, carry_out, overflow}),
              64'd0);
          for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            chk("abort_nodone", 64'(done), 64'd0);
          end
          return;
        end
        start = (cnt - 1 == stop_bit);
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom);
      end else begin
        start = 1'b0;
        chk("done_lat", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("result", 64'(result), 64'(er));
        chk("flags",
            64'({carry_out, overflow}),
            64'({ec, ev}));
      end
    end
    @(negedge clk);
    chk("pulse_end", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("hold_res", 64'(result), 64'(er));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    chk("rst_res",
        64'({result, carry_out, overflow}),
        64'd0);
    start = 1'b1;
    @(negedge clk);
    chk_quiet("rst_start");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_quiet("rst_noqueue");

    run_op(3'b010, 32'h7FFFFFFF, 32'h1, -1, -1);
    run_op(3'b110, 32'd5, 32'd7, -1, -1);
    run_op(3'b110, 32'd7, 32'd5, -1, -1);
    run_op(3'b111, 32'd3, 32'd9, -1, -1);
    run_op(3'b111, 32'd9, 32'd3, -1, -1);
    run_op(3'b111, 32'h80000000, 32'h1, -1, -1);
    run_op(3'b000, 32'hF0F0F0F0, 32'hFF00FF00,
           -1, -1);
    run_op(3'b001, 32'hF0F0F0F0, 32'hFF00FF00,
           -1, -1);
    run_op(3'b011, 32'hFFFFFFFF, 32'h1, -1, -1);
    run_op(3'b010, 32'h12345678, 32'h0BADF00D,
           10, -1);
    run_op(3'b010, 32'hDEADBEEF, 32'h1111, -1, 15);
    run_op(3'b010, 32'd2, 32'd3, -1, -1);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2))
        @(negedge clk);
      run_op(3'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 40)) - 4, -1);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
